// File: rtl/scaler_pkg.sv
// Shared helpers for the code scaler: ceil scale factor, product width and
// channel tag width.
package scaler_pkg;

    localparam int CH_W_MAX = 3;

    // Wide enough for any supported channel count (up to 8).
    typedef logic [CH_W_MAX-1:0] ch_tag_t;

    function automatic longint unsigned calc_factor(longint unsigned out_max,
                                                    int in_w, int shift);
        longint unsigned den;
        longint unsigned num;
        den = (64'd1 << in_w) - 64'd1;
        num = out_max << shift;
        return (num + den - 64'd1) / den;
    endfunction

    function automatic int calc_pw(longint unsigned factor, int in_w);
        return in_w + $clog2(factor + 64'd1);
    endfunction

    function automatic int ch_width(int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/scaler_mul_stage.sv
// S1 register slice of the code scaler: multiplies the accepted code by the
// scale factor and carries the valid bit and channel tag alongside.
module scaler_mul_stage
    import scaler_pkg::*;
#(
    parameter int              IN_W   = 8,
    parameter int              CH_W   = 1,
    parameter int              PW     = 29,
    parameter longint unsigned FACTOR = 64'd1284892
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_code,
    input  logic [CH_W-1:0] in_ch,
    input  logic            s2_adv,
    output logic            s1_valid,
    output logic [PW-1:0]   s1_prod,
    output logic [CH_W-1:0] s1_ch
);

    localparam logic [PW-1:0] FACTOR_V = PW'(FACTOR);

    logic            s1_valid_q, s1_valid_d;
    logic [PW-1:0]   s1_prod_q, s1_prod_d;
    logic [CH_W-1:0] s1_ch_q, s1_ch_d;
    logic            s1_adv;

    // Ready depends only on registered state and downstream ready.
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s1_ch_d    = s1_ch_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_prod_d = {{(PW-IN_W){1'b0}}, in_code} * FACTOR_V;
                s1_ch_d   = in_ch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_ch_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s1_ch_q    <= s1_ch_d;
        end
    end

    assign s1_valid = s1_valid_q;
    assign s1_prod  = s1_prod_q;
    assign s1_ch    = s1_ch_q;

endmodule

// File: rtl/code_scaler_pipe.sv
// Two-stage ADC-code-to-display scaler with saturation and a per-channel
// last-value bank. Define SCALER_ROUND_EN for round-half-up instead of truncation.
module code_scaler_pipe
    import scaler_pkg::*;
#(
    parameter  int IN_W     = 8,
    parameter  int OUT_MAX  = 9999,
    parameter  int OUT_W    = 16,
    parameter  int SHIFT    = 15,
    parameter  int CHANNELS = 2,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_W-1:0]           in_code,
    input  logic [CH_W-1:0]           in_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_value,
    output logic [CH_W-1:0]           out_ch,
    output logic [CHANNELS*OUT_W-1:0] last_value
);

    localparam longint unsigned FACTOR = calc_factor(longint'(OUT_MAX), IN_W, SHIFT);
    localparam int              PW     = calc_pw(FACTOR, IN_W);
    // One spare bit so the rounding add can never wrap.
    localparam int              RW     = (PW + 1 > OUT_W) ? PW + 1 : OUT_W;

`ifdef SCALER_ROUND_EN
    localparam logic [RW-1:0] ROUND_ADD = RW'(1) << (SHIFT - 1);
`else
    localparam logic [RW-1:0] ROUND_ADD = '0;
`endif

    logic            s2_adv;
    logic            s1_valid;
    logic [PW-1:0]   s1_prod;
    logic [CH_W-1:0] s1_ch;

    scaler_mul_stage #(
        .IN_W   (IN_W),
        .CH_W   (CH_W),
        .PW     (PW),
        .FACTOR (FACTOR)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_code  (in_code),
        .in_ch    (in_ch),
        .s2_adv   (s2_adv),
        .s1_valid (s1_valid),
        .s1_prod  (s1_prod),
        .s1_ch    (s1_ch)
    );

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_value_q, out_value_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [OUT_W-1:0] last_q [CHANNELS];
    logic [OUT_W-1:0] last_d [CHANNELS];

    logic [RW-1:0]    sum;
    logic [RW-1:0]    res;
    logic [OUT_W-1:0] sat_value;

    assign s2_adv = !out_valid_q || out_ready;

    always_comb begin
        sum       = RW'(s1_prod) + ROUND_ADD;
        res       = sum >> SHIFT;
        sat_value = (res > RW'(OUT_MAX)) ? OUT_W'(OUT_MAX) : res[OUT_W-1:0];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_ch_d    = out_ch_q;
        if (s2_adv) begin
            out_valid_d = s1_valid;
            if (s1_valid) begin
                out_value_d = sat_value;
                out_ch_d    = s1_ch;
            end
        end
    end

    // Out-of-range tags match no entry, so they are delivered but never banked.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            last_d[k] = last_q[k];
            if (out_valid_q && out_ready && (out_ch_q == CH_W'(k))) begin
                last_d[k] = out_value_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_ch_q    <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                last_q[k] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_ch_q    <= out_ch_d;
            for (int k = 0; k < CHANNELS; k++) begin
                last_q[k] <= last_d[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_ch    = out_ch_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_last
        assign last_value[g*OUT_W +: OUT_W] = last_q[g];
    end

endmodule

// File: tb/tb_code_scaler_pipe.sv
// Randomized scoreboard bench for code_scaler_pipe plus literal pins for the
// default and 10-bit/3300 configurations.
module tb_code_scaler_pipe;

    localparam int OUT_W_A = 16;
    localparam int CHN_A   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Default instance
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [7:0]  in_code = '0;
    logic [0:0]  in_ch = '0, out_ch;
    logic [15:0] out_value;
    logic [31:0] last_value;

    code_scaler_pipe u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_ch(out_ch), .last_value(last_value)
    );

    // 10-bit, 0..3300 instance
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid;
    logic [9:0]  b_in_code = '0;
    logic [0:0]  b_in_ch = '0, b_out_ch;
    logic [11:0] b_out_value, b_last_value;

    code_scaler_pipe #(.IN_W(10), .OUT_MAX(3300), .OUT_W(12), .SHIFT(15), .CHANNELS(1)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code), .in_ch(b_in_ch),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_value(b_out_value),
        .out_ch(b_out_ch), .last_value(b_last_value)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference scaling straight from the arithmetic definition.
    function automatic longint m_scale(longint code, longint out_max, int in_w, int shift);
        longint den, fac, v;
        den = (longint'(1) << in_w) - 1;
        fac = ((out_max << shift) + den - 1) / den;
        v = code * fac;
`ifdef SCALER_ROUND_EN
        v = v + (longint'(1) << (shift - 1));
`endif
        v = v >> shift;
        return (v > out_max) ? out_max : v;
    endfunction

    typedef struct {longint val; int ch; int acc;} item_t;
    item_t  sb[$];
    longint bank_m [CHN_A];
    longint got_q[$];
    longint b_got_q[$];
    bit     collect_en = 0;
    bit     started = 0;
    bit     prev_rst = 1;
    bit     prev_stall = 0;
    longint prev_val = 0;
    int     cyc = 0;

    // Compare process: state is stable at the falling edge; handshakes seen
    // here take effect on the following rising edge.
    always @(negedge clk) begin
        cyc++;
        if (started) begin
            int  occ;
            bit  exp_ov;
            item_t it;
            occ    = sb.size();
            exp_ov = (occ > 0) && (sb[0].acc <= cyc - 2);
            chk("out_valid", longint'(out_valid), longint'(exp_ov));
            chk("in_ready", longint'(in_ready), longint'(!(occ == 2 && !out_ready)));
            if (out_valid && exp_ov) begin
                chk("out_value", longint'(out_value), sb[0].val);
                chk("out_ch", longint'(out_ch), longint'(sb[0].ch));
            end
            for (int k = 0; k < CHN_A; k++)
                chk($sformatf("last_value[%0d]", k), longint'(last_value[k*OUT_W_A +: OUT_W_A]), bank_m[k]);
            if (prev_stall) chk("stall_stable", longint'(out_value), prev_val);
            if (prev_rst) begin
                chk("reset_out_value", longint'(out_value), 0);
                chk("reset_out_ch", longint'(out_ch), 0);
            end
            if (reset) begin
                sb.delete();
                for (int k = 0; k < CHN_A; k++) bank_m[k] = 0;
                prev_stall = 0;
            end else begin
                if (out_valid && out_ready && sb.size() > 0) begin
                    it = sb.pop_front();
                    if (it.ch < CHN_A) bank_m[it.ch] = it.val;
                    if (collect_en) got_q.push_back(longint'(out_value));
                end
                if (in_valid && in_ready)
                    sb.push_back('{m_scale(longint'(in_code), 9999, 8, 15), int'(in_ch), cyc});
                prev_stall = out_valid && !out_ready;
                prev_val   = longint'(out_value);
            end
            prev_rst = reset;
            if (!reset && b_out_valid) b_got_q.push_back(longint'(b_out_value));
        end
        if (reset) started = 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            step();
            n++;
        end
        if (sb.size() > 0) chk({name, "_drain_timeout"}, longint'(sb.size()), 0);
        repeat (2) step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint exp1 [5];
        int     codes1 [5];
        for (int k = 0; k < CHN_A; k++) bank_m[k] = 0;
        codes1 = '{0, 1, 127, 128, 255};
`ifdef SCALER_ROUND_EN
        exp1 = '{0, 39, 4980, 5019, 9999};
`else
        exp1 = '{0, 39, 4979, 5019, 9999};
`endif
        repeat (3) step();
        reset = 1'b0;
        step();

        // Directed codes, ready held high
        collect_en = 1;
        out_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_code = 8'(codes1[i]); in_ch = 1'b0;
            step();
        end
        in_valid = 1'b0;
        drain("directed");
        collect_en = 0;
        chk("directed_count", longint'(got_q.size()), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk($sformatf("directed_code_%0d", codes1[i]), got_q[i], exp1[i]);

        // Two-channel bank
        in_valid = 1'b1; in_code = 8'd64;  in_ch = 1'b0; step();
        in_valid = 1'b1; in_code = 8'd200; in_ch = 1'b1; step();
        in_valid = 1'b0;
        drain("bank");
`ifdef SCALER_ROUND_EN
        chk("bank_ch0", longint'(last_value[15:0]), 2510);
`else
        chk("bank_ch0", longint'(last_value[15:0]), 2509);
`endif
        chk("bank_ch1", longint'(last_value[31:16]), 7842);

        // Random stream with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_code   = 8'($urandom_range(0, 255));
            in_ch     = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain("random");

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 8'd100; in_ch = 1'b0; step();
        in_valid = 1'b1; in_code = 8'd150; in_ch = 1'b1; step();
        in_valid = 1'b0; step();
        chk("pre_reset_full", longint'(in_ready), 0);
        reset = 1'b1; step();
        reset = 1'b0; out_ready = 1'b1;
        repeat (8) step();

        // Second configuration
        b_in_valid = 1'b1; b_in_code = 10'd1023; step();
        b_in_valid = 1'b1; b_in_code = 10'd512;  step();
        b_in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (b_got_q.size() < 2 && n < 20) begin step(); n++; end
        end
        chk("b_count", longint'(b_got_q.size()), 2);
        if (b_got_q.size() >= 2) begin
            chk("b_code_1023", b_got_q[0], 3300);
`ifdef SCALER_ROUND_EN
            chk("b_code_512", b_got_q[1], 1652);
`else
            chk("b_code_512", b_got_q[1], 1651);
`endif
        end

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_scaler_pipe.md
Name: code_scaler_pipe

Overview:
Parametrised, pipelined fixed-point scaler. It maps an IN_W-bit ADC code (0..2^IN_W-1) onto a decimal display range 0..OUT_MAX. It serves up to CHANNELS ADC paths (PWM, R-2R, …) through one shared multiplier, using a valid/ready handshake. It keeps a per-channel "last value" bank so the seven-segment display reads flicker-free values between updates.

Parameters:
IN_W, 8, input code width (2..12)
OUT_MAX, 9999, full-scale output value
OUT_W, 16, output width; must satisfy OUT_MAX < 2^OUT_W
SHIFT, 15, fixed-point fraction bits
CHANNELS, 2, number of channels sharing the block (1..8)
CH_W, $clog2(CHANNELS) min 1, channel tag width (derived localparam)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input code/channel valid
in_ready  out  1  block can accept input this cycle
in_code  in  IN_W  averaged ADC code
in_ch  in  CH_W  channel tag
out_valid  out  1  scaled result valid
out_ready  in  1  downstream accepts result
out_value  out  OUT_W  scaled result
out_ch  out  CH_W  channel tag of out_value
last_value  out  CHANNELS*OUT_W  per-channel most recently delivered value; channel k occupies bits [k*OUT_W +: OUT_W]

Behaviour:
- Clocking: clock clk; reset is synchronous, active-high, named reset.
- FACTOR is a localparam equal to ceil(OUT_MAX * 2^SHIFT / (2^IN_W - 1)). Defaults give FACTOR = 1284892.
- Product width PW = IN_W + $clog2(FACTOR+1). There is no truncation before the shift.
- Stage S1 (multiply): on accept (in_valid && in_ready), register prod = in_code*FACTOR together with the channel tag, and set s1_valid.
- Stage S2 (output): res = prod >> SHIFT (or rounded, see optional feature). Saturate: if res > OUT_MAX, output OUT_MAX. Register the result in out_value/out_ch and set out_valid.
- Advance rules:
  - s2_adv = !out_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv, combinational with no path from in_valid
- Latency: 2 cycles from accept to out_valid. Throughput: 1 per cycle with out_ready held high.
- Stall: while out_valid && !out_ready, out_value/out_ch stay stable and S1 holds. in_ready drops once S1 is full.
- Bubble: if s2_adv is true and s1_valid is false, out_valid clears.
- Last-value bank: on an output handshake (out_valid && out_ready), last_value[out_ch] <= out_value. Other channels are unchanged.
- in_ch >= CHANNELS: the code is processed and delivered normally, but the bank is not written.
- Reset: out_valid=0, s1_valid=0, out_value=0, out_ch=0, all last_value=0. in_ready is 1 in the cycle after reset deasserts. A reset mid-flight discards all in-flight data; no partial output.
- Boundaries: code 0 gives 0. Full-scale code gives exactly OUT_MAX, guaranteed by the ceil factor plus saturation.
- Simultaneous accept and output handshake in the same cycle is legal; both take effect.

Optional Feature:
SCALER_ROUND_EN.
- Defined: S2 computes (prod + 2^(SHIFT-1)) >> SHIFT, round-half-up, then saturates.
- Undefined: plain truncation.
- All other timing and handshake behaviour is identical in both builds.

Decomposition:
- Package scaler_pkg:
  - function calc_factor(out_max, in_w, shift) returning the ceil factor
  - function calc_pw for the product width
  - typedef for the channel tag
- Sub-module scaler_mul_stage: the S1 register slice (multiply, valid, channel pipe). The top level holds S2, saturation and the last-value bank.

Test Plan:
1. Defaults, truncate build, out_ready=1. Codes 0, 1, 127, 128, 255 on ch0 → 0, 39, 4979, 5019, 9999, each 2 cycles after accept.
2. Build with SCALER_ROUND_EN. Code 127 → 4980; code 255 → 9999 (saturation holds); code 1 → 39.
3. Back-to-back stream of 20 codes, out_ready toggled in a random pattern. Required: no loss or duplication, order preserved, out_value stable while stalled, in_ready low when S1 is full.
4. Two channels: ch0 code 64 then ch1 code 200 → last_value ch0 = 2509, ch1 = 7842. ch0 is untouched by the ch1 write.
5. Assert reset with 2 items in flight → next cycle out_valid=0 and last_value all 0. No stale output appears after reset deasserts.
6. IN_W=10, OUT_MAX=3300 (FACTOR = ceil(3300*32768/1023)). Code 1023 → 3300; code 512 → 1651.
